// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin fetch/execute sharing of one simple dual-port BRAM with base relocation.
// Defining MEM_ARB_LIMIT_CHECK_EN adds a logical-limit check that faults out-of-range requests.
module mem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int PHYS_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_valid,
    output logic [DATA_W-1:0] f_data,
    input  logic              e_req,
    input  logic              e_we,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_gnt,
    output logic              e_valid,
    output logic [DATA_W-1:0] e_data,
    input  logic [PHYS_W-1:0] base,
    input  logic [ADDR_W:0]   limit,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr,
    output logic              ram_ena,
    output logic              ram_wea,
    output logic [PHYS_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dia,
    output logic              ram_enb,
    output logic [PHYS_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_dob
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state_q, state_d;
    logic last_e_q, last_e_d;
    logic sel_e_q, sel_e_d;
    logic we_q, we_d;
    logic flt_q, flt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic f_gnt_q, f_gnt_d, e_gnt_q, e_gnt_d;
    logic f_valid_q, f_valid_d, e_valid_q, e_valid_d;
    logic [DATA_W-1:0] f_data_q, f_data_d, e_data_q, e_data_d;
    logic fault_q, fault_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
    logic ram_ena_q, ram_ena_d, ram_wea_q, ram_wea_d, ram_enb_q, ram_enb_d;
    logic [PHYS_W-1:0] ram_addra_q, ram_addra_d, ram_addrb_q, ram_addrb_d;
    logic [DATA_W-1:0] ram_dia_q, ram_dia_d;
    logic win_e, req_we, req_flt;
    logic [ADDR_W-1:0] req_addr;
    logic [PHYS_W-1:0] phys;
    // On a tie the requester not served last wins
    assign win_e    = e_req & (~f_req | ~last_e_q);
    assign req_we   = win_e & e_we;
    assign req_addr = win_e ? e_addr : f_addr;
    assign phys     = base + PHYS_W'(req_addr);
`ifdef MEM_ARB_LIMIT_CHECK_EN
    assign req_flt = {1'b0, req_addr} >= limit;
`else
    logic unused_limit;
    assign unused_limit = ^limit;
    assign req_flt = 1'b0;
`endif
    always_comb begin
        state_d      = state_q;
        last_e_d     = last_e_q;
        sel_e_d      = sel_e_q;
        we_d         = we_q;
        flt_d        = flt_q;
        addr_d       = addr_q;
        f_gnt_d      = 1'b0;
        e_gnt_d      = 1'b0;
        f_valid_d    = 1'b0;
        e_valid_d    = 1'b0;
        f_data_d     = f_data_q;
        e_data_d     = e_data_q;
        fault_d      = 1'b0;
        fault_addr_d = fault_addr_q;
        ram_ena_d    = 1'b0;
        ram_wea_d    = 1'b0;
        ram_enb_d    = 1'b0;
        ram_addra_d  = ram_addra_q;
        ram_addrb_d  = ram_addrb_q;
        ram_dia_d    = ram_dia_q;
        case (state_q)
            IDLE: if (f_req || e_req) begin
                state_d  = ISSUE;
                last_e_d = win_e;
                sel_e_d  = win_e;
                we_d     = req_we;
                flt_d    = req_flt;
                addr_d   = req_addr;
                f_gnt_d  = ~win_e;
                e_gnt_d  = win_e;
                if (!req_flt && req_we) begin
                    ram_ena_d   = 1'b1;
                    ram_wea_d   = 1'b1;
                    ram_addra_d = phys;
                    ram_dia_d   = e_wdata;
                end else if (!req_flt) begin
                    ram_enb_d   = 1'b1;
                    ram_addrb_d = phys;
                end
            end
            ISSUE: begin
                state_d = (we_q || flt_q) ? IDLE : WAIT;
                if (flt_q) begin
                    f_valid_d    = ~sel_e_q;
                    e_valid_d    = sel_e_q;
                    fault_d      = 1'b1;
                    fault_addr_d = addr_q;
                    f_data_d     = sel_e_q ? f_data_q : '0;
                    e_data_d     = sel_e_q ? '0 : e_data_q;
                end else begin
                    e_valid_d = we_q;
                end
            end
            WAIT: begin
                state_d   = IDLE;
                f_valid_d = ~sel_e_q;
                e_valid_d = sel_e_q;
                f_data_d  = sel_e_q ? f_data_q : ram_dob;
                e_data_d  = sel_e_q ? ram_dob : e_data_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_e_q     <= 1'b1;
            sel_e_q      <= 1'b0;
            we_q         <= 1'b0;
            flt_q        <= 1'b0;
            addr_q       <= '0;
            f_gnt_q      <= 1'b0;
            e_gnt_q      <= 1'b0;
            f_valid_q    <= 1'b0;
            e_valid_q    <= 1'b0;
            f_data_q     <= '0;
            e_data_q     <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
            ram_ena_q    <= 1'b0;
            ram_wea_q    <= 1'b0;
            ram_enb_q    <= 1'b0;
            ram_addra_q  <= '0;
            ram_addrb_q  <= '0;
            ram_dia_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_e_q     <= last_e_d;
            sel_e_q      <= sel_e_d;
            we_q         <= we_d;
            flt_q        <= flt_d;
            addr_q       <= addr_d;
            f_gnt_q      <= f_gnt_d;
            e_gnt_q      <= e_gnt_d;
            f_valid_q    <= f_valid_d;
            e_valid_q    <= e_valid_d;
            f_data_q     <= f_data_d;
            e_data_q     <= e_data_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
            ram_ena_q    <= ram_ena_d;
            ram_wea_q    <= ram_wea_d;
            ram_enb_q    <= ram_enb_d;
            ram_addra_q  <= ram_addra_d;
            ram_addrb_q  <= ram_addrb_d;
            ram_dia_q    <= ram_dia_d;
        end
    end
    assign f_gnt      = f_gnt_q;
    assign e_gnt      = e_gnt_q;
    assign f_valid    = f_valid_q;
    assign e_valid    = e_valid_q;
    assign f_data     = f_data_q;
    assign e_data     = e_data_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
    assign ram_ena    = ram_ena_q;
    assign ram_wea    = ram_wea_q;
    assign ram_enb    = ram_enb_q;
    assign ram_addra  = ram_addra_q;
    assign ram_addrb  = ram_addrb_q;
    assign ram_dia    = ram_dia_q;
endmodule
